// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer
// Receive-side buffer between uart_rx and uart_ctrl. The receiver's byte-ready
// level is synchronized into clk and edge-detected. Each detected byte is
// captured with its frame/parity error flags into a first-word-fall-through
// FIFO. Occupancy, a sticky overrun flag and a threshold interrupt are provided.
//
// Ports:
//   clk            system clock (only clock)
//   rst            synchronous active-high reset
//   rx_data        received byte, stable while rx_update is high
//   rx_frame_err   frame error of current byte
//   rx_parity_err  parity error of current byte
//   rx_update      byte-ready level, asynchronous to clk
//   rd_req         pop head entry (ignored when empty)
//   rd_data        head entry {parity_err, frame_err, data}, valid when !empty
//   empty / full   FIFO occupancy flags
//   count          number of entries, 0..DP
//   thresh         interrupt threshold, 0 disables
//   irq            registered, thresh != 0 && count >= thresh
//   overrun        sticky: a byte was dropped because the FIFO was full
//   overrun_clr    pulse clearing overrun (a simultaneous overrun wins)
//   flush          pulse discarding all entries
module uart_rx_buffer #(
  parameter int DP = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_frame_err,
  input  logic          rx_parity_err,
  input  logic          rx_update,
  input  logic          rd_req,
  output logic [9:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  input  logic [AW:0]   thresh,
  output logic          irq,
  output logic          overrun,
  input  logic          overrun_clr,
  input  logic          flush
);

  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DP);
  localparam logic [AW:0]   CNT_ZERO_C = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE_C  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ZERO_C = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE_C  = {{(AW-1){1'b0}}, 1'b1};

  logic            s1_q, s2_q, s3_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overrun_q, overrun_d;
  logic            irq_q, irq_d;
  logic [9:0]      mem_q [DP];

  logic            push_evt_s;
  logic            empty_s;
  logic            full_s;
  logic            pop_ok_s;
  logic            wr_en_s;
  logic            ovr_evt_s;

  // A held-high rx_update yields exactly one event: rising edge of s2.
  assign push_evt_s = s2_q & ~s3_q;
  assign empty_s    = (count_q == CNT_ZERO_C);
  assign full_s     = (count_q == DEPTH_C);

  // Resolve push/pop/flush for this cycle and compute next-state values.
  always_comb begin
    pop_ok_s  = 1'b0;
    wr_en_s   = 1'b0;
    ovr_evt_s = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    irq_d     = 1'b0;

    if (flush) begin
      // Flush discards any same-cycle push or pop; the lost push never
      // counts as an overrun.
      wr_ptr_d = PTR_ZERO_C;
      rd_ptr_d = PTR_ZERO_C;
      count_d  = CNT_ZERO_C;
    end else begin
      pop_ok_s  = rd_req & ~empty_s;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      wr_en_s   = push_evt_s & (~full_s | pop_ok_s);
      ovr_evt_s = push_evt_s & full_s & ~pop_ok_s;

      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE_C;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE_C;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({wr_en_s, pop_ok_s})
        2'b10:   count_d = count_q + CNT_ONE_C;
        2'b01:   count_d = count_q - CNT_ONE_C;
        default: count_d = count_q;
      endcase
    end

    // Set has priority over clear.
    if (ovr_evt_s) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    irq_d = (thresh != CNT_ZERO_C) && (count_d >= thresh);
  end

  // Synchronizer, pointers, count and flags with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      wr_ptr_q  <= PTR_ZERO_C;
      rd_ptr_q  <= PTR_ZERO_C;
      count_q   <= CNT_ZERO_C;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      s1_q      <= rx_update;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end

  // Entry storage; data inputs are stable while rx_update is high, so they
  // are sampled directly. Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= {rx_parity_err, rx_frame_err, rx_data};
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = empty_s;
  assign full    = full_s;
  assign count   = count_q;
  assign irq     = irq_q;
  assign overrun = overrun_q;

endmodule
